// File: rtl/el_frame_loader.sv
// Packs a 1-bpp byte stream into rows of a double-buffered row RAM and
// swaps display banks on the first vsync rising edge after a full frame.
module el_frame_loader #(
   parameter int H_PIXELS = 512,
   parameter int V_LINES  = 256
) (
   input  logic                       clk_50,
   input  logic                       rst,
   input  logic [7:0]                 s_data,
   input  logic                       s_valid,
   input  logic                       s_sof,
   output logic                       s_ready,
   input  logic                       disp_vs,
   output logic                       wr_en,
   output logic [$clog2(V_LINES):0]   wr_addr,
   output logic [H_PIXELS-1:0]        wr_data,
   output logic                       disp_bank,
   output logic                       frame_done,
   output logic                       sync_err
);

   localparam int ROW_BYTES = H_PIXELS / 8;
   localparam int BW        = $clog2(ROW_BYTES);
   localparam int RW        = $clog2(V_LINES);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, PEND} state_t;

   state_t                 state, state_d;
   logic [RW-1:0]          row, row_d;
   logic [BW-1:0]          byte_idx, byte_d;
   logic [H_PIXELS-1:0]    data_d;
   logic [RW:0]            addr_d;
   logic                   wr_en_d;
   logic                   bank_d;
   logic                   done_d;
   logic                   err_d;
   logic                   vs_q;
   logic                   vs_rise;
   logic                   xfer;
   logic                   last_byte;
   logic                   last_row;
   logic [7:0]             pix;

   // pixel order: s_data[7] is the leftmost pixel, i.e. the lowest bit
   always_comb begin
      pix = '0;
      for (int i = 0; i < 8; i++) pix[i] = s_data[7-i];
   end

   assign s_ready   = (state == IDLE) || (state == FILL);
   assign xfer      = s_valid && s_ready;
   assign vs_rise   = disp_vs && !vs_q;
   assign last_byte = (byte_idx == BW'(ROW_BYTES - 1));
   assign last_row  = (row == RW'(V_LINES - 1));

   always_comb begin
      state_d = state;
      row_d   = row;
      byte_d  = byte_idx;
      data_d  = wr_data;
      addr_d  = wr_addr;
      wr_en_d = 1'b0;
      bank_d  = disp_bank;
      done_d  = 1'b0;
      err_d   = sync_err;
      unique case (state)
         IDLE: begin
            if (xfer && s_sof) begin
               data_d[7:0] = pix;
               row_d       = '0;
               byte_d      = BW'(1);
               state_d     = FILL;
            end
         end
         FILL: begin
            if (xfer && s_sof) begin
               err_d       = 1'b1;
               data_d[7:0] = pix;
               row_d       = '0;
               byte_d      = BW'(1);
            end else if (xfer) begin
               data_d[{byte_idx, 3'b000} +: 8] = pix;
               if (last_byte) begin
                  wr_en_d = 1'b1;
                  addr_d  = {~disp_bank, row};
                  state_d = WRITE;
               end else begin
                  byte_d = byte_idx + BW'(1);
               end
            end
         end
         WRITE: begin
            if (last_row) begin
               state_d = PEND;
            end else begin
               row_d   = row + RW'(1);
               byte_d  = '0;
               state_d = FILL;
            end
         end
         PEND: begin
            if (vs_rise) begin
               bank_d  = ~disp_bank;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         byte_idx   <= '0;
         wr_data    <= '0;
         wr_addr    <= '0;
         wr_en      <= 1'b0;
         disp_bank  <= 1'b0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         vs_q       <= 1'b0;
      end else begin
         state      <= state_d;
         row        <= row_d;
         byte_idx   <= byte_d;
         wr_data    <= data_d;
         wr_addr    <= addr_d;
         wr_en      <= wr_en_d;
         disp_bank  <= bank_d;
         frame_done <= done_d;
         sync_err   <= err_d;
         vs_q       <= disp_vs;
      end
   end

endmodule

// File: tb/tb_el_frame_loader.sv
// Directed-sequence bench for el_frame_loader with random pixel data,
// random source gaps and a queue of expected row writes.
module tb_el_frame_loader;

   localparam int H  = 512;
   localparam int V  = 256;
   localparam int RB = H / 8;

   logic          clk_50 = 1'b0;
   logic          rst;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_sof;
   logic          s_ready;
   logic          disp_vs;
   logic          wr_en;
   logic [8:0]    wr_addr;
   logic [H-1:0]  wr_data;
   logic          disp_bank;
   logic          frame_done;
   logic          sync_err;

   typedef struct {
      logic [8:0]   addr;
      logic [H-1:0] data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_w;
   int         tests   = 0;
   int         failed  = 0;
   int         wr_cnt  = 0;
   logic [7:0] rb [RB];

   el_frame_loader #(.H_PIXELS(H), .V_LINES(V)) dut (
      .clk_50     (clk_50),
      .rst        (rst),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_sof      (s_sof),
      .s_ready    (s_ready),
      .disp_vs    (disp_vs),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .disp_bank  (disp_bank),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #10 clk_50 = ~clk_50;

   task automatic chk(input string tag, input logic [H-1:0] obs,
                      input logic [H-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one byte offered at a negedge, held until the loader takes it
   task automatic send(input logic [7:0] d, input logic sof);
      int n;
      if ($urandom_range(0, 7) == 0) begin
         s_valid = 1'b0;
         @(negedge clk_50);
      end
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      n = 0;
      while (!s_ready && n < 200) begin
         @(negedge clk_50);
         n++;
      end
      if (!s_ready) begin
         tests++;
         failed++;
         $display("FAIL send_timeout: s_ready 0 required 1");
         $display("[TB] %0d tests run, %0d failed", tests, failed);
         $fatal(1, "source stalled");
      end
      @(negedge clk_50);
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   // pixel x of a row is bit (7 - x%8) of byte x/8
   task automatic push_row(input int r, input logic bank);
      wr_t w;
      w.addr = {bank, 8'(r)};
      for (int x = 0; x < H; x++) w.data[x] = rb[x / 8][7 - (x % 8)];
      exp_q.push_back(w);
   endtask

   task automatic send_row(input int r, input logic bank, input bit sof0,
                           input bit bitord);
      for (int k = 0; k < RB; k++)
         rb[k] = bitord ? ((k == 0) ? 8'h01 : 8'h00) : 8'($urandom);
      push_row(r, bank);
      for (int k = 0; k < RB; k++) send(rb[k], sof0 && (k == 0));
   endtask

   always @(negedge clk_50) begin
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            chk("wr_spurious", H'(exp_q.size()), H'(1));
         end else begin
            mon_w = exp_q.pop_front();
            chk("wr_addr", H'(wr_addr), H'(mon_w.addr));
            chk("wr_data", wr_data, mon_w.data);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      disp_vs = 1'b0;
      #5;
      chk("rst_ready", H'(s_ready), H'(1));
      chk("rst_wr_en", H'(wr_en), H'(0));
      chk("rst_bank", H'(disp_bank), H'(0));
      repeat (3) @(negedge clk_50);
      rst = 1'b0;
      chk("rel_ready", H'(s_ready), H'(1));
      chk("rel_wr_addr", H'(wr_addr), H'(0));
      chk("rel_wr_data", wr_data, H'(0));
      chk("rel_done", H'(frame_done), H'(0));
      chk("rel_err", H'(sync_err), H'(0));

      // bytes before any start-of-frame are dropped
      for (int k = 0; k < 5; k++) send(8'($urandom), 1'b0);
      @(negedge clk_50);
      chk("garbage_writes", H'(wr_cnt), H'(0));
      chk("garbage_ready", H'(s_ready), H'(1));

      // frame 1 into bank 1
      for (int r = 0; r < V; r++) send_row(r, 1'b1, r == 0, 1'b0);
      @(negedge clk_50);
      for (int i = 0; i < 5; i++) begin
         chk("pend_ready", H'(s_ready), H'(0));
         chk("pend_done", H'(frame_done), H'(0));
         @(negedge clk_50);
      end
      chk("f1_writes", H'(wr_cnt), H'(V));
      chk("f1_queue", H'(exp_q.size()), H'(0));
      chk("f1_bank", H'(disp_bank), H'(0));
      chk("f1_err", H'(sync_err), H'(0));

      disp_vs = 1'b1;
      @(negedge clk_50);
      chk("swap_done", H'(frame_done), H'(1));
      chk("swap_bank", H'(disp_bank), H'(1));
      chk("swap_ready", H'(s_ready), H'(1));
      @(negedge clk_50);
      chk("swap_done_off", H'(frame_done), H'(0));
      disp_vs = 1'b0;

      // frame 2 into bank 0, bit-order row, then a resync at row 3 byte 10
      send_row(0, 1'b0, 1'b1, 1'b1);
      chk("bitord_wr_en", H'(wr_en), H'(1));
      chk("bitord_data", wr_data, H'(8'h80));
      chk("bitord_ready", H'(s_ready), H'(0));
      send_row(1, 1'b0, 1'b0, 1'b0);
      send_row(2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) send(8'($urandom), 1'b0);
      chk("pre_resync_err", H'(sync_err), H'(0));
      send_row(0, 1'b0, 1'b1, 1'b0);
      chk("resync_err", H'(sync_err), H'(1));
      for (int r = 1; r < V - 1; r++) send_row(r, 1'b0, 1'b0, 1'b0);
      disp_vs = 1'b1;
      send_row(V - 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_50);
      for (int i = 0; i < 4; i++) begin
         chk("vs_high_bank", H'(disp_bank), H'(1));
         chk("vs_high_done", H'(frame_done), H'(0));
         @(negedge clk_50);
      end
      chk("f2_writes", H'(wr_cnt), H'(2 * V + 3));
      chk("f2_err_sticky", H'(sync_err), H'(1));
      disp_vs = 1'b0;
      @(negedge clk_50);
      disp_vs = 1'b1;
      @(negedge clk_50);
      chk("swap2_done", H'(frame_done), H'(1));
      chk("swap2_bank", H'(disp_bank), H'(0));
      @(negedge clk_50);
      disp_vs = 1'b0;

      // asynchronous reset in the middle of a row
      send(8'hff, 1'b1);
      for (int k = 0; k < 19; k++) send(8'hff, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("arst_wr_data", wr_data, H'(0));
      chk("arst_wr_addr", H'(wr_addr), H'(0));
      chk("arst_err", H'(sync_err), H'(0));
      chk("arst_ready", H'(s_ready), H'(1));
      chk("arst_bank", H'(disp_bank), H'(0));
      @(negedge clk_50);
      rst = 1'b0;
      chk("arst_rel_ready", H'(s_ready), H'(1));
      send_row(0, 1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk_50);
      chk("post_rst_queue", H'(exp_q.size()), H'(0));
      chk("post_rst_writes", H'(wr_cnt), H'(2 * V + 4));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/el_frame_loader.md
# el_frame_loader

Upstream feeder for the EL panel scan driver. It receives a byte stream of 1-bpp pixel data and packs it into 512-bit rows. It writes those rows into the back half of a double-buffered row RAM, and swaps banks at the scanner's next vertical sync once a full frame has been written. The scan driver reads rows from bank `disp_bank`, addressed by its line counter, while the loader fills the other bank.

## Interface
- `H_PIXELS`, 512: pixels per row; must be a multiple of 8. Sets `wr_data` width.
- `V_LINES`, 256: rows per frame.
- `ROW_BYTES`, H_PIXELS/8 = 64: bytes per row (derived, not overridable).
- `clk_50`  in  1  system clock. Single clock domain; the scanner is also in this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  8  pixel byte; bit 7 is the leftmost pixel; 1 = pixel lit.
- `s_valid`  in  1  byte present on `s_data`.
- `s_sof`  in  1  qualifies the current byte as the first byte of a frame.
- `s_ready`  out  1  loader accepts the byte. A transfer occurs when `s_valid && s_ready`.
- `disp_vs`  in  1  scanner vsync level; high during scanner line 0.
- `wr_en`  out  1  one-cycle row-RAM write strobe.
- `wr_addr`  out  1+clog2(V_LINES)  row-RAM address: {bank, row}.
- `wr_data`  out  H_PIXELS  packed row. Bit x is pixel x.
- `disp_bank`  out  1  bank the scanner must read.
- `frame_done`  out  1  one-cycle pulse when the bank swap occurs.
- `sync_err`  out  1  sticky flag: `s_sof` arrived mid-frame. Cleared only by `rst`.

## Operation
- State machine states: IDLE, FILL, WRITE, PEND.
- `s_ready` is 1 in IDLE and FILL and 0 in WRITE and PEND. It is decoded from the registered state.
- **IDLE:**
  - A transfer without `s_sof` is consumed and discarded.
  - A transfer with `s_sof` stores the byte as byte 0, sets row=0 and byte_idx=1, and moves to FILL.
- **FILL:**
  - Each transfer stores byte k = byte_idx into `wr_data[8k+7:8k]`, bit-reversed so that `s_data[7]` lands at pixel 8k.
  - When byte ROW_BYTES-1 is accepted, the state moves to WRITE.
  - A transfer with `s_sof` in FILL sets `sync_err`, restarts at row=0 with this byte as byte 0, and stays in FILL. This applies even on row 0 byte 0 of a re-sent frame.
- **WRITE:**
  - `wr_en`=1 for exactly one cycle, with `wr_addr`={~disp_bank, row}.
  - If row==V_LINES-1, the state moves to PEND.
  - Otherwise row increments, byte_idx=0, and the state returns to FILL.
- **PEND:**
  - Waits for a vsync rising edge: `vs_rise = disp_vs & ~vs_q`, where `vs_q` is `disp_vs` registered.
  - On `vs_rise`, `disp_bank` toggles, `frame_done` pulses, and the state moves to IDLE.
- `vs_rise` has no effect in IDLE, FILL or WRITE. `disp_bank` changes only from PEND.
- `wr_data` holds its value between writes. Bytes not yet overwritten in the current row keep stale values, but a row is written only after all ROW_BYTES bytes have been accepted.
- byte_idx is clog2(ROW_BYTES) bits wide and row is clog2(V_LINES) bits wide. Neither counter wraps implicitly; both are reset by explicit compare.

## Timing
- Reset values: state=IDLE (so `s_ready`=1 immediately after reset release), `wr_en`=0, `wr_addr`=0, `wr_data`=0, `disp_bank`=0, `frame_done`=0, `sync_err`=0, `vs_q`=0, row=0, byte_idx=0.
- Reset asserted mid-frame aborts the frame. The partial bank contents are irrelevant because `disp_bank` returns to 0.
- Last byte of a row accepted at edge N: `wr_en` is high during cycle N+1 and `s_ready` is low during cycle N+1. The next byte can be accepted at edge N+2.
- Row throughput is ROW_BYTES+1 cycles minimum. A full frame takes V_LINES·(ROW_BYTES+1) = 16640 cycles minimum at default parameters.
- `disp_vs` rises at edge M (so `vs_rise` is true in cycle M→M+1, while in PEND): `disp_bank` toggles and `frame_done` is high after edge M+1. `s_ready` returns high in the same cycle.
- `disp_vs` already high when PEND is entered: no swap occurs until the next rising edge.
- `s_valid` may stay high while `s_ready`=0; the byte is held by the source and not lost.

## Test plan
- **Reset:** assert `rst` asynchronously mid-FILL → all outputs go to their reset values without a clock edge; `s_ready`=1 after release.
- **Single frame:** send `s_sof` + 16384 bytes of 0x80, hold `disp_vs`=0 → 256 `wr_en` pulses with `wr_addr` 256..511 (bank 1); each `wr_data` has bits 0, 8, 16, … set; `s_ready` stays 0 in PEND.
- **Swap:** after the single-frame test, pulse `disp_vs` → `disp_bank`=1 and a one-cycle `frame_done` exactly one cycle after the rise. The next frame writes `wr_addr` 0..255.
- **Bit order:** a row with byte 0 = 0x01 and all other bytes = 0x00 → `wr_data` has only bit 7 set.
- **Resync:** `s_sof` at row 3, byte 10 → `sync_err`=1 and stays 1. The next `wr_en` occurs after ROW_BYTES−1 more bytes, with row 0.
- **Pre-sof garbage and backpressure:** send 5 bytes without `s_sof` → no writes. Hold `s_valid` high through WRITE → the byte is accepted only after `wr_en`, and nothing is lost.
